// File: rtl/pixel_arbiter_grid_pkg.sv
// rtl/pixel_arbiter_grid_pkg.sv - shared FSM state type and width helpers for the pixel arbiter
package pixel_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROW_SEL = 2'd1,
    COL_SEL = 2'd2,
    GRANT   = 2'd3
  } state_t;

  // Index width for an N-entry vector, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pixel_arbiter_grid_if.sv
// rtl/pixel_arbiter_grid_if.sv - pixel event inputs and grant/handshake outputs of the arbiter
interface pixel_arbiter_grid_if #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DROPW = 8
) ();
  import pixel_arb_pkg::*;

  localparam int XW = idx_w(ROWS);
  localparam int YW = idx_w(COLS);

  logic                       enable;
  logic [ROWS-1:0][COLS-1:0]  set;
  logic                       ready_i;
  logic                       valid_o;
  logic [ROWS-1:0][COLS-1:0]  gnt_o;
  logic [XW-1:0]              x_add;
  logic [YW-1:0]              y_add;
  logic                       req;
  logic [DROPW-1:0]           drop_cnt;

  modport master (
    input  enable, set, ready_i,
    output valid_o, gnt_o, x_add, y_add, req, drop_cnt
  );

  modport slave (
    output enable, set, ready_i,
    input  valid_o, gnt_o, x_add, y_add, req, drop_cnt
  );

endinterface

// File: rtl/pixel_arbiter_grid_rr_pick.sv
// rtl/pixel_arbiter_grid_rr_pick.sv - combinational round-robin search starting at ptr_i with wrap
module rr_pick
  import pixel_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o
);

  logic [W:0]   cand;
  logic [W-1:0] cand_w;

  // One extra bit on the candidate sum so ptr+k can be folded back below N.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = '0;
    cand_w   = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_i} + (W+1)'(k);
      if (cand >= (W+1)'(N)) begin
        cand = cand - (W+1)'(N);
      end
      cand_w = cand[W-1:0];
      if (!found_o && req_i[cand_w]) begin
        found_o          = 1'b1;
        idx_o            = cand_w;
        onehot_o[cand_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_arbiter_grid.sv
// rtl/pixel_arbiter_grid.sv - pending-map pixel arbiter, row-first then column round-robin
module pixel_arbiter_grid
  import pixel_arb_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int DROPW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pixel_arbiter_grid_if.master bus
);

  localparam int XW   = idx_w(ROWS);
  localparam int YW   = idx_w(COLS);
  localparam int PCW  = cnt_w(ROWS * COLS);
  localparam int SUMW = ((DROPW > PCW) ? DROPW : PCW) + 1;
  localparam logic [DROPW-1:0] DROP_MAX = '1;

  state_t                    state_q, state_d;
  logic [ROWS-1:0][COLS-1:0] pending_q, pending_d;
  logic [XW-1:0]             row_ptr_q, row_ptr_d, x_add_q, x_add_d;
  logic [YW-1:0]             col_ptr_q, col_ptr_d, y_add_q, y_add_d;
  logic [ROWS-1:0]           sel_row_q, sel_row_d;
  logic [COLS-1:0]           sel_col_q, sel_col_d;
  logic [DROPW-1:0]          drop_q, drop_d;

  logic [ROWS-1:0][COLS-1:0] gnt, clr, dup;
  logic [ROWS-1:0]           row_any, row_oh;
  logic [COLS-1:0]           col_oh, row_rest;
  logic [XW-1:0]             row_idx;
  logic [YW-1:0]             col_idx;
  logic                      row_found, col_found;
  logic                      granting, handshake, any_other;
  logic [PCW-1:0]            dup_cnt;
  logic [SUMW-1:0]           drop_sum;

  rr_pick #(.N(ROWS)) u_row_pick (
    .req_i    (row_any),
    .ptr_i    (row_ptr_q),
    .found_o  (row_found),
    .idx_o    (row_idx),
    .onehot_o (row_oh)
  );

  rr_pick #(.N(COLS)) u_col_pick (
    .req_i    (pending_q[x_add_q]),
    .ptr_i    (col_ptr_q),
    .found_o  (col_found),
    .idx_o    (col_idx),
    .onehot_o (col_oh)
  );

  assign granting  = (state_q == GRANT);
  assign handshake = granting & bus.ready_i;

  always_comb begin
    gnt     = '0;
    row_any = '0;
    for (int i = 0; i < ROWS; i++) begin
      row_any[i] = |pending_q[i];
      for (int j = 0; j < COLS; j++) begin
        gnt[i][j] = granting & sel_row_q[i] & sel_col_q[j];
      end
    end
  end

  // Set wins over clear on the same pixel; only sets onto a surviving bit count as drops.
  assign clr       = handshake ? gnt : '0;
  assign dup       = bus.set & pending_q & ~clr;
  assign pending_d = (pending_q & ~clr) | bus.set;
  assign row_rest  = pending_q[x_add_q] & ~sel_col_q;
  assign any_other = |(pending_q & ~clr);

  always_comb begin
    dup_cnt = '0;
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        dup_cnt = dup_cnt + PCW'(dup[i][j]);
      end
    end
    drop_sum = SUMW'(drop_q) + SUMW'(dup_cnt);
    drop_d   = (drop_sum > SUMW'(DROP_MAX)) ? DROP_MAX : drop_sum[DROPW-1:0];
  end

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    col_ptr_d = col_ptr_q;
    x_add_d   = x_add_q;
    y_add_d   = y_add_q;
    sel_row_d = sel_row_q;
    sel_col_d = sel_col_q;
    case (state_q)
      IDLE: begin
        if (bus.enable && bus.req) begin
          state_d = ROW_SEL;
        end
      end
      ROW_SEL: begin
        if (!bus.enable || !row_found) begin
          state_d = IDLE;
        end else begin
          x_add_d   = row_idx;
          sel_row_d = row_oh;
          state_d   = COL_SEL;
        end
      end
      COL_SEL: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (col_found) begin
          y_add_d   = col_idx;
          sel_col_d = col_oh;
          state_d   = GRANT;
        end else begin
          state_d = ROW_SEL;
        end
      end
      GRANT: begin
        if (bus.ready_i) begin
          col_ptr_d = (y_add_q == YW'(COLS - 1)) ? '0 : y_add_q + 1'b1;
          if (|row_rest) begin
            state_d = bus.enable ? COL_SEL : IDLE;
          end else begin
            // Row drained: advance to the next row and restart its column scan.
            row_ptr_d = (x_add_q == XW'(ROWS - 1)) ? '0 : x_add_q + 1'b1;
            col_ptr_d = '0;
            state_d   = (bus.enable && any_other) ? ROW_SEL : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      row_ptr_q <= '0;
      col_ptr_q <= '0;
      x_add_q   <= '0;
      y_add_q   <= '0;
      sel_row_q <= '0;
      sel_col_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      row_ptr_q <= row_ptr_d;
      col_ptr_q <= col_ptr_d;
      x_add_q   <= x_add_d;
      y_add_q   <= y_add_d;
      sel_row_q <= sel_row_d;
      sel_col_q <= sel_col_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.valid_o  = granting;
  assign bus.gnt_o    = gnt;
  assign bus.x_add    = x_add_q;
  assign bus.y_add    = y_add_q;
  assign bus.req      = |pending_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_pixel_arbiter_grid.sv
// tb/tb_pixel_arbiter_grid.sv - self-checking bench for pixel_arbiter_grid (4x4 and 5x3 instances)
module tb_pixel_arbiter_grid;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  pixel_arbiter_grid_if #(.ROWS(4), .COLS(4), .DROPW(8)) if1 ();
  pixel_arbiter_grid_if #(.ROWS(5), .COLS(3), .DROPW(8)) if2 ();

  pixel_arbiter_grid #(.ROWS(4), .COLS(4), .DROPW(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pixel_arbiter_grid #(.ROWS(5), .COLS(3), .DROPW(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [3:0] sb1[$];
  logic [7:0] sb2[$];
  bit         sb2_on = 1'b0;

  typedef struct packed {
    logic [15:0] set_map;
    logic [31:0] exp;
    logic [31:0] n_exp;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain1(input string nm, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (sb1.size() == 0 && !if1.valid_o && !if1.req) break;
      tick();
    end
    chk({nm, " drained in time"}, 32'(k < budget), 32'd1);
  endtask

  task automatic drain2(input string nm, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (sb2.size() == 0 && !if2.valid_o && !if2.req) break;
      tick();
    end
    chk({nm, " drained in time"}, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_valid1(input string nm, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (if1.valid_o) break;
      tick();
    end
    chk({nm, " valid_o in time"}, 32'(k < budget), 32'd1);
  endtask

  // Scoreboard for the 4x4 instance: entries are {x[1:0], y[1:0]}, which is also the flat grant bit.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n == 1'b0 && if1.valid_o && if1.ready_i) begin
      if (sb1.size() == 0) begin
        chk("sb1 grant with empty queue", 32'(sb1.size()), 32'd1);
      end else begin
        e = sb1.pop_front();
        chk("sb1 x_add", 32'(if1.x_add), 32'(e[3:2]));
        chk("sb1 y_add", 32'(if1.y_add), 32'(e[1:0]));
        chk("sb1 gnt_o", 32'(if1.gnt_o), 32'(16'd1 << e));
      end
    end
    if (!if1.valid_o) chk("gnt_o zero while idle", 32'(if1.gnt_o), 32'd0);
  end

  always @(negedge clk) begin
    logic [7:0] e2;
    if (rst_n == 1'b0 && if2.valid_o) begin
      chk("g2 x_add in range", 32'(if2.x_add < 3'd5), 32'd1);
      chk("g2 y_add in range", 32'(if2.y_add < 2'd3), 32'd1);
      chk("g2 gnt_o matches address", 32'(if2.gnt_o), 32'(15'd1 << (if2.x_add * 3 + if2.y_add)));
      if (if2.ready_i && sb2_on) begin
        if (sb2.size() == 0) begin
          chk("sb2 grant with empty queue", 32'(sb2.size()), 32'd1);
        end else begin
          e2 = sb2.pop_front();
          chk("sb2 x_add", 32'(if2.x_add), 32'(e2[7:4]));
          chk("sb2 y_add", 32'(if2.y_add), 32'(e2[3:0]));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got %0d tests, expected completion", tests);
    $fatal(1);
  end

  initial begin
    // set bit index = x*4+y; exp nibble k = k-th expected grant {x,y}
    vecs[0] = '{16'h4090, 32'h0000_0E74, 32'd3};
    vecs[1] = '{16'h040F, 32'h000A_3210, 32'd5};
    vecs[2] = '{16'h8102, 32'h0000_081F, 32'd3};
    vecs[3] = '{16'h1000, 32'h0000_000C, 32'd1};
    vecs[4] = '{16'h0F20, 32'h000B_A985, 32'd5};
    vecs[5] = '{16'h8001, 32'h0000_000F, 32'd2};

    rst_n = 1'b1;
    if1.enable = 1'b0; if1.set = '0; if1.ready_i = 1'b0;
    if2.enable = 1'b0; if2.set = '0; if2.ready_i = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    chk("reset valid_o", 32'(if1.valid_o), 32'd0);
    chk("reset gnt_o", 32'(if1.gnt_o), 32'd0);
    chk("reset x_add", 32'(if1.x_add), 32'd0);
    chk("reset y_add", 32'(if1.y_add), 32'd0);
    chk("reset req", 32'(if1.req), 32'd0);
    chk("reset drop_cnt", 32'(if1.drop_cnt), 32'd0);
    chk("reset g2 valid_o", 32'(if2.valid_o), 32'd0);

    // Single event latency: pulse in cycle 0, grant visible in cycle 4.
    if1.enable = 1'b1; if1.ready_i = 1'b1;
    sb1.push_back(4'h9);
    if1.set = 16'h0200;
    tick();
    if1.set = '0;
    for (int c = 1; c < 4; c++) begin
      chk("latency valid_o low before cycle 4", 32'(if1.valid_o), 32'd0);
      tick();
    end
    chk("latency valid_o cycle 4", 32'(if1.valid_o), 32'd1);
    chk("latency x_add", 32'(if1.x_add), 32'd2);
    chk("latency y_add", 32'(if1.y_add), 32'd1);
    chk("latency gnt_o", 32'(if1.gnt_o), 32'h0200);
    tick();
    chk("latency req cleared", 32'(if1.req), 32'd0);
    chk("latency valid_o cycle 5", 32'(if1.valid_o), 32'd0);

    rst_n = 1'b1; tick(); rst_n = 1'b0;

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < int'(vecs[v].n_exp); k++) sb1.push_back(4'(vecs[v].exp >> (4 * k)));
      if1.set = vecs[v].set_map;
      tick();
      if1.set = '0;
      drain1($sformatf("vector %0d", v), 200);
    end

    // Grant on (0,2) held with ready low; duplicate pulse must be counted as a drop.
    if1.ready_i = 1'b0;
    if1.set = 16'h0004;
    tick();
    if1.set = '0;
    wait_valid1("hold", 20);
    for (int c = 0; c < 10; c++) begin
      chk("hold valid_o", 32'(if1.valid_o), 32'd1);
      chk("hold x_add", 32'(if1.x_add), 32'd0);
      chk("hold y_add", 32'(if1.y_add), 32'd2);
      chk("hold gnt_o", 32'(if1.gnt_o), 32'h0004);
      if1.set = (c == 3) ? 16'h0004 : 16'h0000;
      tick();
    end
    if1.set = '0;
    chk("hold drop_cnt", 32'(if1.drop_cnt), 32'd1);
    sb1.push_back(4'h2);
    if1.ready_i = 1'b1;
    tick();
    if1.ready_i = 1'b0;
    chk("after hold valid_o", 32'(if1.valid_o), 32'd0);
    chk("after hold req", 32'(if1.req), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("no regrant valid_o", 32'(if1.valid_o), 32'd0);
    end

    // Set coinciding with the clearing handshake keeps the pixel pending and it is granted again.
    if1.set = 16'h0004;
    tick();
    if1.set = '0;
    wait_valid1("coincident", 20);
    sb1.push_back(4'h2);
    sb1.push_back(4'h2);
    if1.ready_i = 1'b1;
    if1.set = 16'h0004;
    tick();
    if1.set = '0;
    drain1("coincident regrant", 50);
    chk("coincident drop_cnt unchanged", 32'(if1.drop_cnt), 32'd1);

    // Disable while in COL_SEL: back to IDLE with the event still pending.
    sb1.push_back(4'hB);
    if1.set = 16'h0800;
    tick();
    if1.set = '0;
    tick(); tick();
    if1.enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("disabled valid_o", 32'(if1.valid_o), 32'd0);
      chk("disabled req kept", 32'(if1.req), 32'd1);
    end
    if1.enable = 1'b1;
    drain1("re-enable", 50);

    // Drop counter saturation with every pixel pulsed while nothing is cleared.
    rst_n = 1'b1; if1.ready_i = 1'b0; tick(); rst_n = 1'b0;
    if1.set = '1;
    for (int c = 0; c < 16; c++) tick();
    chk("drop_cnt 15x16", 32'(if1.drop_cnt), 32'd240);
    tick();
    chk("drop_cnt saturates", 32'(if1.drop_cnt), 32'd255);
    tick();
    chk("drop_cnt stays saturated", 32'(if1.drop_cnt), 32'd255);
    if1.set = '0;
    rst_n = 1'b1; tick(); rst_n = 1'b0;
    chk("reset mid-grant drop_cnt", 32'(if1.drop_cnt), 32'd0);
    chk("reset mid-grant req", 32'(if1.req), 32'd0);
    chk("reset mid-grant valid_o", 32'(if1.valid_o), 32'd0);

    // Reset during GRANT with three pixels pending and a nonzero drop count.
    if1.set = 16'h8420;
    tick();
    if1.set = '0;
    wait_valid1("reset grant", 20);
    chk("reset grant x_add", 32'(if1.x_add), 32'd1);
    if1.set = 16'h0020;
    tick();
    if1.set = '0;
    chk("reset grant drop before", 32'(if1.drop_cnt), 32'd1);
    rst_n = 1'b1; tick(); rst_n = 1'b0;
    chk("rst grant valid_o", 32'(if1.valid_o), 32'd0);
    chk("rst grant req", 32'(if1.req), 32'd0);
    chk("rst grant drop_cnt", 32'(if1.drop_cnt), 32'd0);
    chk("rst grant gnt_o", 32'(if1.gnt_o), 32'd0);
    chk("rst grant x_add", 32'(if1.x_add), 32'd0);
    chk("rst grant y_add", 32'(if1.y_add), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst grant stays idle", 32'(if1.valid_o), 32'd0);
    end

    // 5x3 instance: wrap from row 4 back to row 0, then random traffic with range checks.
    if2.enable = 1'b1; if2.ready_i = 1'b1; sb2_on = 1'b1;
    sb2.push_back({4'd3, 4'd0});
    if2.set = 15'h0200;
    tick();
    if2.set = '0;
    drain2("g2 row 3", 50);
    sb2.push_back({4'd4, 4'd2});
    sb2.push_back({4'd0, 4'd0});
    if2.set = 15'h4001;
    tick();
    if2.set = '0;
    drain2("g2 wrap", 50);
    sb2_on = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if2.set = 15'($urandom) & 15'($urandom) & 15'($urandom);
      if2.ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    if2.set = '0;
    if2.ready_i = 1'b1;
    drain2("g2 random", 300);

    chk("sb1 empty at end", 32'(sb1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pixel_arbiter_grid.md
Name: pixel_arbiter_grid

Overview:
Parametrised successor of the fixed 4x4 pixel-level arbiter. Latches per-pixel event pulses from a ROWS x COLS array into a pending map and arbitrates them row-first, then column, both round-robin. Presents one granted pixel at a time (one-hot grant plus x/y address) over a valid/ready handshake to the next hierarchy level. Adds event buffering and a drop counter.

Parameters:
ROWS, 4, number of pixel rows (>=2)
COLS, 4, number of pixel columns (>=2)
XW, $clog2(ROWS), row address width (derived, localparam)
YW, $clog2(COLS), column address width (derived, localparam)
DROPW, 8, width of saturating drop counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous, active-high reset (name kept per codebase; asserted = 1)
enable  in  1  arbitration enable
set  in  [ROWS-1:0][COLS-1:0]  per-pixel event pulses, sampled every cycle
ready_i  in  1  downstream accepts current grant
valid_o  out  1  grant/address valid
gnt_o  out  [ROWS-1:0][COLS-1:0]  one-hot grant, zero when valid_o=0
x_add  out  XW  granted row index
y_add  out  YW  granted column index
req  out  1  OR of pending map (request to upper level)
drop_cnt  out  DROPW  saturating count of events lost to already-pending pixels

Behaviour:
- Reset (rst_n=1 at an edge): pending=0, state=IDLE, row_ptr=0, col_ptr=0, drop_cnt=0; outputs valid_o=0, gnt_o=0, x_add=0, y_add=0, req=0. Reset mid-handshake discards the grant and all pending events.
- Pending map: pending[i][j] <= (pending[i][j] & ~clr[i][j]) | set[i][j]. clr is asserted only for the granted pixel in the handshake cycle (valid_o & ready_i). Set and clear on the same pixel in the same cycle: set wins (bit stays 1).
- Drop: set[i][j]=1 while pending[i][j]=1 and not being cleared increments drop_cnt by the number of such bits (popcount), saturating at 2^DROPW-1.
- req = |pending (registered map, combinational OR).
- FSM states (shared package enum): IDLE, ROW_SEL, COL_SEL, GRANT.
  IDLE: enable & req -> ROW_SEL, else stay.
  ROW_SEL: pick the first row with any pending bit, searching from row_ptr upward with wrap; latch it into x_add -> COL_SEL. If no row is pending (cleared meanwhile) -> IDLE.
  COL_SEL: pick the first pending column in row x_add, searching from col_ptr with wrap; latch it into y_add -> GRANT. If none -> ROW_SEL.
  GRANT: valid_o=1, gnt_o[x_add][y_add]=1. Hold all outputs stable until ready_i=1. On the handshake, col_ptr <= y_add+1 (wrap at COLS). Next state: if other bits remain pending in row x_add -> COL_SEL (row drained before moving on); else row_ptr <= x_add+1 (wrap at ROWS), col_ptr <= 0 -> ROW_SEL if enable & any other pending, else IDLE.
- enable=0: in ROW_SEL/COL_SEL -> IDLE next cycle, pointers unchanged. In GRANT, the handshake must complete first, then -> IDLE. Pending capture continues regardless of enable.
- Latency: set pulse in cycle 0 -> pending in cycle 1 -> ROW_SEL cycle 2 -> COL_SEL cycle 3 -> valid_o=1 in cycle 4 (idle array, enable=1). Back-to-back in the same row: one GRANT every 2 cycles with ready_i tied high.
- Pointer wrap: index ROWS-1 increments to 0. Non-power-of-two ROWS/COLS must never produce an index >= ROWS/COLS.

Decomposition:
- Package pixel_arb_pkg: state_t enum, helper function for index width (min 1 bit).
- Sub-module rr_pick #(N): combinational round-robin search; inputs req[N-1:0] and ptr, outputs found, idx, onehot. Instantiated twice (row select over the per-row OR vector, column select over pending[x_add]).

Test Plan:
- Single event set[2][1] in cycle 0, ready_i=1 -> valid_o=1 in cycle 4 with x_add=2, y_add=1, gnt_o only [2][1]; pending cleared, req=0 in cycle 5.
- Pixels [1][0],[1][3],[3][2] set together, ready_i=1 -> grant order (1,0),(1,3),(3,2); row 1 drained before row 3.
- Hold ready_i=0 for 10 cycles during GRANT on (0,2) -> outputs stable; set[0][2] pulsed meanwhile -> drop_cnt=1; after handshake pixel re-granted only if set coincided with the clear cycle.
- Wrap: after granting row ROWS-1, a pending row 0 is picked next; with ROWS=5, COLS=3, x_add never exceeds 4 and y_add never exceeds 2.
- enable dropped in COL_SEL -> IDLE next cycle, valid_o stays 0, pending preserved; re-enable -> the same pixel is granted.
- rst_n asserted in GRANT with 3 pixels pending -> next cycle valid_o=0, req=0, drop_cnt=0, state IDLE.
